// File: rtl/am_envelope_demod_if.sv
// I/Q sample strobes in, envelope audio/magnitude strobes out.
// The source of I/Q samples is the master; the demodulator is the slave.
interface am_envelope_demod_if #(
   parameter int IQ_BITS = 16
);
   logic                      i_tick;
   logic signed [IQ_BITS-1:0] i_in;
   logic                      q_tick;
   logic signed [IQ_BITS-1:0] q_in;
   logic signed [IQ_BITS-1:0] audio;
   logic        [IQ_BITS-1:0] mag;
   logic                      audio_tick;
   logic                      pair_err;

   modport master (
      output i_tick, i_in, q_tick, q_in,
      input  audio, mag, audio_tick, pair_err
   );

   modport slave (
      input  i_tick, i_in, q_tick, q_in,
      output audio, mag, audio_tick, pair_err
   );
endinterface

// File: rtl/am_envelope_demod.sv
// AM envelope detector: pairs I/Q samples, alpha-max-beta-min magnitude,
// leaky-integrator DC removal. Fixed 4-cycle latency from completing tick to audio_tick.
module am_envelope_demod #(
   parameter int IQ_BITS  = 16,
   parameter int DC_SHIFT = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   am_envelope_demod_if.slave bus
);
   localparam int N     = IQ_BITS;
   localparam int ACC_W = IQ_BITS + DC_SHIFT;

   logic                i_pend_q, i_pend_d, q_pend_q, q_pend_d;
   logic signed [N-1:0] i_hold_q, i_hold_d, q_hold_q, q_hold_d;
   logic                perr_q, perr_d;
   logic                s0_vld_q, s1_vld_q, s2_vld_q, out_vld_q;
   logic signed [N-1:0] s0_i_q, s0_i_d, s0_q_q, s0_q_d;
   logic        [N-1:0] s1_mx_q, s1_mx_d, s1_mn_q, s1_mn_d;
   logic        [N-1:0] s2_mag_q, s2_mag_d;
   logic        [ACC_W-1:0] acc_q, acc_d;
   logic signed [N-1:0] audio_q, audio_d;
   logic        [N-1:0] mag_q;

   logic                pair_fire;
   logic        [N-1:0] abs_i, abs_q, dc_est;
   logic        [N:0]   diff;

   // Magnitude of a signed sample; the most negative code saturates to full scale.
   function automatic logic [N-1:0] sat_abs(input logic signed [N-1:0] s);
      logic [N-1:0] r;
      r = s;
      if (s[N-1]) begin
         r = -s;
         if (s == {1'b1, {(N-1){1'b0}}}) r = {1'b0, {(N-1){1'b1}}};
      end
      return r;
   endfunction

   always_comb begin
      i_pend_d = i_pend_q;
      q_pend_d = q_pend_q;
      i_hold_d = i_hold_q;
      q_hold_d = q_hold_q;
      perr_d   = 1'b0;

      pair_fire = (i_pend_q | bus.i_tick) & (q_pend_q | bus.q_tick);
      s0_i_d    = bus.i_tick ? bus.i_in : i_hold_q;
      s0_q_d    = bus.q_tick ? bus.q_in : q_hold_q;

      if (pair_fire) begin
         i_pend_d = 1'b0;
         q_pend_d = 1'b0;
      end else begin
         perr_d = (bus.i_tick & i_pend_q) | (bus.q_tick & q_pend_q);
         if (bus.i_tick) begin
            i_pend_d = 1'b1;
            i_hold_d = bus.i_in;
         end
         if (bus.q_tick) begin
            q_pend_d = 1'b1;
            q_hold_d = bus.q_in;
         end
      end

      abs_i   = sat_abs(s0_i_q);
      abs_q   = sat_abs(s0_q_q);
      s1_mx_d = (abs_i >= abs_q) ? abs_i : abs_q;
      s1_mn_d = (abs_i >= abs_q) ? abs_q : abs_i;

      // 15/16*max + 15/32*min never exceeds N unsigned bits.
      s2_mag_d = s1_mx_q - (s1_mx_q >> 4) + (s1_mn_q >> 1) - (s1_mn_q >> 5);

      dc_est  = acc_q[ACC_W-1:DC_SHIFT];
      diff    = {1'b0, s2_mag_q} - {1'b0, dc_est};
      audio_d = diff[N-1:0];
      if (diff[N] != diff[N-1]) audio_d = diff[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      acc_d = acc_q;
      if (s2_vld_q) acc_d = acc_q + ACC_W'(s2_mag_q) - ACC_W'(dc_est);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         i_pend_q  <= 1'b0;
         q_pend_q  <= 1'b0;
         i_hold_q  <= '0;
         q_hold_q  <= '0;
         perr_q    <= 1'b0;
         s0_vld_q  <= 1'b0;
         s1_vld_q  <= 1'b0;
         s2_vld_q  <= 1'b0;
         out_vld_q <= 1'b0;
         s0_i_q    <= '0;
         s0_q_q    <= '0;
         s1_mx_q   <= '0;
         s1_mn_q   <= '0;
         s2_mag_q  <= '0;
         acc_q     <= '0;
         audio_q   <= '0;
         mag_q     <= '0;
      end else begin
         i_pend_q  <= i_pend_d;
         q_pend_q  <= q_pend_d;
         i_hold_q  <= i_hold_d;
         q_hold_q  <= q_hold_d;
         perr_q    <= perr_d;
         s0_vld_q  <= pair_fire;
         s1_vld_q  <= s0_vld_q;
         s2_vld_q  <= s1_vld_q;
         out_vld_q <= s2_vld_q;
         acc_q     <= acc_d;
         if (pair_fire) begin
            s0_i_q <= s0_i_d;
            s0_q_q <= s0_q_d;
         end
         if (s0_vld_q) begin
            s1_mx_q <= s1_mx_d;
            s1_mn_q <= s1_mn_d;
         end
         if (s1_vld_q) s2_mag_q <= s2_mag_d;
         if (s2_vld_q) begin
            audio_q <= audio_d;
            mag_q   <= s2_mag_q;
         end
      end
   end

   assign bus.audio      = audio_q;
   assign bus.mag        = mag_q;
   assign bus.audio_tick = out_vld_q;
   assign bus.pair_err   = perr_q;
endmodule

// File: tb/tb_am_envelope_demod.sv
// Directed bench for am_envelope_demod: reference model feeds a scoreboard of
// expected outputs and pair_err cycles; a negedge monitor compares.
module tb_am_envelope_demod;
   localparam int SH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   tick_cnt = 0;

   typedef struct {
      int cyc;
      int mag;
      int audio;
   } exp_t;

   exp_t sb[$];
   int   perr_q[$];

   bit      m_ip, m_qp;
   int      m_ih, m_qh;
   longint  m_acc;

   am_envelope_demod_if #(.IQ_BITS(16)) ifc ();

   am_envelope_demod #(.IQ_BITS(16), .DC_SHIFT(SH)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (ifc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int sabs(int v);
      int a;
      a = (v < 0) ? -v : v;
      if (a > 32767) a = 32767;
      return a;
   endfunction

   function automatic int mag_model(int i, int q);
      int ai, aq, mx, mn;
      ai = sabs(i);
      aq = sabs(q);
      mx = (ai > aq) ? ai : aq;
      mn = (ai > aq) ? aq : ai;
      return mx - mx / 16 + mn / 2 - mn / 32;
   endfunction

   task automatic push_pair(int i, int q);
      exp_t e;
      int   m, dc, a;
      m  = mag_model(i, q);
      dc = int'(m_acc / (64'sd1 << SH));
      a  = m - dc;
      if (a > 32767) a = 32767;
      if (a < -32768) a = -32768;
      m_acc = m_acc + m - dc;
      e.cyc = cyc;
      e.mag = m;
      e.audio = a;
      sb.push_back(e);
   endtask

   task automatic model_reset();
      m_ip = 0;
      m_qp = 0;
      m_ih = 0;
      m_qh = 0;
      m_acc = 0;
   endtask

   // One cycle of stimulus; the model decides pairing and overrun.
   task automatic step(input bit it, input int iv, input bit qt, input int qv);
      bit fire, ovr;
      fire = (m_ip | it) & (m_qp | qt);
      ovr  = !fire && ((it && m_ip) || (qt && m_qp));
      if (fire) begin
         push_pair(it ? iv : m_ih, qt ? qv : m_qh);
         m_ip = 0;
         m_qp = 0;
      end else begin
         if (it) begin m_ip = 1; m_ih = iv; end
         if (qt) begin m_qp = 1; m_qh = qv; end
      end
      if (ovr) perr_q.push_back(cyc + 1);
      ifc.i_tick = it;
      ifc.i_in   = 16'(iv);
      ifc.q_tick = qt;
      ifc.q_in   = 16'(qv);
      @(posedge clk);
      #1;
      ifc.i_tick = 1'b0;
      ifc.q_tick = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (ifc.audio_tick === 1'b1) begin
            tick_cnt++;
            chk("tick_expected", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("latency", cyc, e.cyc + 4);
               chk("mag", {16'd0, ifc.mag}, e.mag);
               chk("audio", ifc.audio, e.audio);
            end
         end
         if (ifc.pair_err === 1'b1) begin
            chk("perr_expected", int'(perr_q.size() != 0), 1);
            if (perr_q.size() != 0) chk("perr_cycle", cyc, perr_q.pop_front());
         end
      end
   end

   initial begin
      int n0, prev;
      model_reset();
      ifc.i_tick = 1'b0;
      ifc.q_tick = 1'b0;
      ifc.i_in   = '0;
      ifc.q_in   = '0;

      // Reset held 4 cycles with ticks toggling
      for (int k = 0; k < 4; k++) begin
         ifc.i_tick = k[0];
         ifc.q_tick = ~k[0];
         ifc.i_in   = 16'(k * 1000 + 7);
         ifc.q_in   = 16'(k * 500 + 3);
         @(posedge clk);
         #1;
      end
      chk("rst_audio", ifc.audio, 0);
      chk("rst_mag", {16'd0, ifc.mag}, 0);
      chk("rst_tick", {31'd0, ifc.audio_tick}, 0);
      chk("rst_perr", {31'd0, ifc.pair_err}, 0);
      rst = 1'b0;
      ifc.i_tick = 1'b0;
      ifc.q_tick = 1'b0;
      idle(6);
      chk("post_rst_ticks", tick_cnt, 0);
      chk("post_rst_mag", {16'd0, ifc.mag}, 0);

      // Basic pair
      step(1, 3000, 1, 4000);
      idle(4);
      chk("t2_mag", {16'd0, ifc.mag}, 5157);
      chk("t2_audio", ifc.audio, 5157);

      // Most-negative input saturates
      step(1, -32768, 1, 0);
      idle(4);
      chk("t3_mag_i", {16'd0, ifc.mag}, 30720);
      step(1, 0, 1, -32768);
      idle(4);
      chk("t3_mag_q", {16'd0, ifc.mag}, 30720);

      // Skewed ticks, then I overrun
      step(1, 111, 0, 0);
      idle(2);
      step(0, 0, 1, 4000);
      idle(6);
      step(1, 100, 0, 0);
      idle(3);
      step(1, 5000, 0, 0);
      idle(5);
      step(0, 0, 1, 0);
      idle(5);
      chk("t4_mag_newest_i", {16'd0, ifc.mag}, 4688);

      // Reset while a pair is in flight
      n0 = tick_cnt;
      step(1, 3000, 1, 4000);
      idle(1);
      rst = 1'b1;
      void'(sb.pop_back());
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(4);
      chk("t6_no_tick", tick_cnt, n0);
      step(1, 3000, 1, 4000);
      idle(4);
      chk("t6_mag", {16'd0, ifc.mag}, 5157);
      chk("t6_audio", ifc.audio, 5157);

      // DC removal from a fresh accumulator
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      prev = 32767;
      for (int k = 0; k < 4096; k++) begin
         step(1, 1000, 1, 0);
         idle(4);
         if (k == 0) chk("t5_first", ifc.audio, 938);
         if (k == 1) chk("t5_second", ifc.audio, 935);
         if (k > 0) chk("t5_monotonic", int'(int'(ifc.audio) <= prev), 1);
         prev = int'(ifc.audio);
      end
      chk("t5_settled", int'(ifc.audio >= -1 && ifc.audio <= 1), 1);
      chk("t5_mag", {16'd0, ifc.mag}, 938);

      idle(6);
      chk("sb_drained", sb.size(), 0);
      chk("perr_drained", perr_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
